// File: rtl/cdc_fifo_arb_pkg.sv
// Shared types and helpers for the cdc_fifo_arb source-side arbiter.
package cdc_fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // A single requester still carries a 1-bit ID so the payload framing stays fixed.
  function automatic int unsigned calc_id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/cdc_fifo_arb_rr.sv
// Combinational round-robin pick: first requester after rr_ptr, scanning upward with wrap.
module cdc_fifo_arb_rr #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant_oh,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                any_valid
);

  always_comb begin
    int unsigned idx;
    logic        found;
    found    = 1'b0;
    idx      = 0;
    grant_oh = '0;
    // With nothing requesting, report the scan start so the idle ID is predictable.
    grant_id = ID_WIDTH'((32'(rr_ptr) + 1) % NUM_REQ);
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_id      = ID_WIDTH'(idx);
      end
    end
    any_valid = |req;
  end

endmodule

// File: rtl/cdc_fifo_arb.sv
// Round-robin burst-locking arbiter in front of cdc_fifo src port; prepends grant ID to each beat.
// Optional burst limit: define CDC_FIFO_ARB_BURST_LIMIT_EN to force release every MAX_BURST beats.
module cdc_fifo_arb
  import cdc_fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned MAX_BURST  = 16,
  localparam int unsigned ID_WIDTH   = calc_id_width(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [ID_WIDTH+DATA_WIDTH-1:0]      fifo_data_o,
  output logic                                fifo_valid_o,
  input  logic                                fifo_ready_i,
  output logic [ID_WIDTH-1:0]                 grant_id_o,
  output logic                                busy_o
);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;
  logic [ID_WIDTH-1:0] rr_id, grant;
  logic [NUM_REQ-1:0]  rr_oh, grant_oh;
  logic                rr_any, hs, rel;

`ifdef CDC_FIFO_ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
`endif

  cdc_fifo_arb_rr #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req       (req_valid_i),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (rr_oh),
    .grant_id  (rr_id),
    .any_valid (rr_any)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
      lock_id_q  <= '0;
`ifdef CDC_FIFO_ARB_BURST_LIMIT_EN
      beat_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
`ifdef CDC_FIFO_ARB_BURST_LIMIT_EN
      beat_cnt_q <= beat_cnt_d;
`endif
    end
  end

  // Valid is masked by reset so nothing is offered or accepted while reset is held.
  always_comb begin
    grant_oh = '0;
    if (state_q == LOCK) begin
      grant               = lock_id_q;
      grant_oh[lock_id_q] = 1'b1;
      fifo_valid_o        = rst_n_i & req_valid_i[lock_id_q];
    end else begin
      grant        = rr_id;
      grant_oh     = rr_oh;
      fifo_valid_o = rst_n_i & rr_any;
    end
    hs          = fifo_valid_o & fifo_ready_i;
    req_ready_o = grant_oh & {NUM_REQ{hs}};
    fifo_data_o = {grant, req_data_i[grant]};
    grant_id_o  = grant;
    busy_o      = (state_q == LOCK);
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_id_d  = lock_id_q;
`ifdef CDC_FIFO_ARB_BURST_LIMIT_EN
    beat_cnt_d = beat_cnt_q;
    rel        = req_last_i[grant] |
                 ((beat_cnt_q + CNT_WIDTH'(1)) == CNT_WIDTH'(MAX_BURST));
`else
    rel        = req_last_i[grant];
`endif
    case (state_q)
      IDLE: begin
        if (hs && rel) begin
          rr_ptr_d = grant;
        end else if (fifo_valid_o) begin
          // Lock even without a handshake so the shown grant survives backpressure.
          state_d   = LOCK;
          lock_id_d = grant;
`ifdef CDC_FIFO_ARB_BURST_LIMIT_EN
          beat_cnt_d = hs ? CNT_WIDTH'(1) : '0;
`endif
        end
      end
      LOCK: begin
        if (hs && rel) begin
          state_d  = IDLE;
          rr_ptr_d = lock_id_q;
`ifdef CDC_FIFO_ARB_BURST_LIMIT_EN
          beat_cnt_d = '0;
`endif
        end else if (hs) begin
`ifdef CDC_FIFO_ARB_BURST_LIMIT_EN
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cdc_fifo_arb.sv
// Scoreboard testbench for cdc_fifo_arb (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
module tb_cdc_fifo_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_valid, req_last, req_ready;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [DW+1:0]          fifo_data;
  logic                   fifo_valid, fifo_ready, busy;
  logic [1:0]             grant_id;

  int unsigned   pend [NR];
  int unsigned   sent [NR];
  int unsigned   bsz  [NR];
  logic [DW+1:0] sb[$];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  cdc_fifo_arb #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_last_i   (req_last),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .fifo_data_o  (fifo_data),
    .fifo_valid_o (fifo_valid),
    .fifo_ready_i (fifo_ready),
    .grant_id_o   (grant_id),
    .busy_o       (busy)
  );

  function automatic logic [DW-1:0] bd(input int unsigned id, input int unsigned n);
    return 32'hA5A5_0000 + DW'(n << 8) + DW'(id);
  endfunction

  function automatic logic [DW+1:0] ent(input int unsigned id, input int unsigned n);
    return {2'(id), bd(id, n)};
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (pend[i] != 0);
      req_data[i]  = bd(i, sent[i]);
      req_last[i]  = (pend[i] != 0) && (((sent[i] + 1) % bsz[i]) == 0);
    end
  endtask

  task automatic finish_cycle(input logic [NR-1:0] got);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (got[i]) begin
        pend[i]--;
        sent[i]++;
      end
    end
    drive();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      pend[i] = 0;
      sent[i] = 0;
      bsz[i]  = 1;
    end
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    fifo_ready = 1'b0;
    clear_reqs();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] top;
    rst_n      = 1'b0;
    fifo_ready = 1'b1;
    clear_reqs();
    for (int i = 0; i < NR; i++) pend[i] = 1;
    drive();
    @(negedge clk);
    total++;
    if (fifo_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, expected 0", fifo_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b, expected 0000", req_ready); end
    clear_reqs();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (fifo_valid !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL rst_idle: got valid=%b id=%0d ready=%b, expected valid=0 id=0 ready=0000",
               fifo_valid, grant_id, req_ready);
    end
    for (int i = 0; i < NR; i++) pend[i] = 1;
    drive();
    #1;
    top = fifo_data[DW+1:DW];
    total++;
    if (fifo_valid !== 1'b1 || grant_id !== 2'd0 || top !== 2'd0) begin
      bad++;
      $display("FAIL rst_first: got valid=%b id=%0d data_id=%0d, expected valid=1 id=0 data_id=0",
               fifo_valid, grant_id, top);
    end
    total++;
    if (fifo_data[DW-1:0] !== bd(0, 0)) begin
      bad++;
      $display("FAIL rst_first_data: got %h, expected %h", fifo_data[DW-1:0], bd(0, 0));
    end
  endtask

  task automatic test_round_robin();
    logic [DW+1:0] exp_v;
    logic [NR-1:0] got;
    int cyc;
    do_reset();
    fifo_ready = 1'b1;
    pend[0] = 2; pend[1] = 2; pend[2] = 1; pend[3] = 1;
    sb.push_back(ent(0, 0)); sb.push_back(ent(1, 0)); sb.push_back(ent(2, 0));
    sb.push_back(ent(3, 0)); sb.push_back(ent(0, 1)); sb.push_back(ent(1, 1));
    drive();
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      @(negedge clk);
      got = req_ready;
      if (fifo_valid === 1'b1 && fifo_ready === 1'b1) begin
        total++;
        exp_v = sb.pop_front();
        if (fifo_data !== exp_v) begin bad++; $display("FAIL rr_beat: got %h, expected %h", fifo_data, exp_v); end
      end
      cyc++;
      finish_cycle(got);
    end
    total++;
    if (sb.size() != 0 || cyc != 6) begin
      bad++;
      $display("FAIL rr_bubbles: got %0d cycles with %0d beats left, expected 6 cycles 0 left", cyc, sb.size());
    end
  endtask

  task automatic test_burst_lock();
    logic [DW+1:0] exp_v;
    logic [NR-1:0] got;
    int cyc, nhs;
    do_reset();
    fifo_ready = 1'b1;
    pend[1] = 3; bsz[1] = 3;
    pend[2] = 1;
    sb.push_back(ent(1, 0)); sb.push_back(ent(1, 1)); sb.push_back(ent(1, 2)); sb.push_back(ent(2, 0));
    drive();
    cyc = 0;
    nhs = 0;
    while (sb.size() != 0 && cyc < 20) begin
      @(negedge clk);
      got = req_ready;
      if (nhs < 3) begin
        total++;
        if (req_ready[2] !== 1'b0) begin bad++; $display("FAIL lock_req2_ready: got %b, expected 0", req_ready[2]); end
      end
      if (fifo_valid === 1'b1 && fifo_ready === 1'b1) begin
        total++;
        nhs++;
        exp_v = sb.pop_front();
        if (fifo_data !== exp_v) begin bad++; $display("FAIL lock_beat: got %h, expected %h", fifo_data, exp_v); end
      end
      cyc++;
      finish_cycle(got);
    end
    total++;
    if (sb.size() != 0 || cyc != 4) begin
      bad++;
      $display("FAIL lock_cycles: got %0d cycles with %0d beats left, expected 4 cycles 0 left", cyc, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DW+1:0] exp_v;
    logic [NR-1:0] got;
    int cyc;
    do_reset();
    pend[2] = 1;
    drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      got = req_ready;
      total++;
      if (grant_id !== 2'd2 || fifo_data !== ent(2, 0) || fifo_valid !== 1'b1 || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold: got id=%0d data=%h valid=%b ready=%b, expected id=2 data=%h valid=1 ready=0000",
                 grant_id, fifo_data, fifo_valid, req_ready, ent(2, 0));
      end
      finish_cycle(got);
      if (c == 0) begin
        pend[0] = 1;
        drive();
      end
    end
    fifo_ready = 1'b1;
    sb.push_back(ent(2, 0)); sb.push_back(ent(0, 0));
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      @(negedge clk);
      got = req_ready;
      if (fifo_valid === 1'b1 && fifo_ready === 1'b1) begin
        total++;
        exp_v = sb.pop_front();
        if (fifo_data !== exp_v) begin bad++; $display("FAIL bp_beat: got %h, expected %h", fifo_data, exp_v); end
      end
      cyc++;
      finish_cycle(got);
    end
    total++;
    if (sb.size() != 0 || cyc != 2) begin
      bad++;
      $display("FAIL bp_drain: got %0d cycles with %0d beats left, expected 2 cycles 0 left", cyc, sb.size());
    end
  endtask

  task automatic test_burst_limit();
    logic [DW+1:0] exp_v;
    logic [NR-1:0] got;
    int cyc;
    do_reset();
    fifo_ready = 1'b1;
    pend[0] = 10; bsz[0] = 10;
    pend[3] = 1;
`ifdef CDC_FIFO_ARB_BURST_LIMIT_EN
    for (int n = 0; n < 4; n++) sb.push_back(ent(0, n));
    sb.push_back(ent(3, 0));
    for (int n = 4; n < 10; n++) sb.push_back(ent(0, n));
`else
    for (int n = 0; n < 10; n++) sb.push_back(ent(0, n));
    sb.push_back(ent(3, 0));
`endif
    drive();
    cyc = 0;
    while (sb.size() != 0 && cyc < 40) begin
      @(negedge clk);
      got = req_ready;
      if (fifo_valid === 1'b1 && fifo_ready === 1'b1) begin
        total++;
        exp_v = sb.pop_front();
        if (fifo_data !== exp_v) begin bad++; $display("FAIL limit_beat: got %h, expected %h", fifo_data, exp_v); end
      end
      cyc++;
      finish_cycle(got);
    end
    total++;
    if (sb.size() != 0 || cyc != 11) begin
      bad++;
      $display("FAIL limit_cycles: got %0d cycles with %0d beats left, expected 11 cycles 0 left", cyc, sb.size());
    end
  endtask

  task automatic test_mid_burst_reset();
    logic [DW+1:0] exp_v;
    logic [NR-1:0] got;
    int cyc;
    do_reset();
    fifo_ready = 1'b1;
    pend[1] = 4; bsz[1] = 4;
    sb.push_back(ent(1, 0));
    drive();
    @(negedge clk);
    got = req_ready;
    if (fifo_valid === 1'b1 && fifo_ready === 1'b1) begin
      total++;
      exp_v = sb.pop_front();
      if (fifo_data !== exp_v) begin bad++; $display("FAIL mbr_first: got %h, expected %h", fifo_data, exp_v); end
    end
    finish_cycle(got);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mbr_busy_lock: got %b, expected 1", busy); end
    rst_n   = 1'b0;
    pend[0] = 1;
    drive();
    #1;
    total++;
    if (busy !== 1'b0 || req_ready !== 4'b0000 || fifo_valid !== 1'b0) begin
      bad++;
      $display("FAIL mbr_in_reset: got busy=%b ready=%b valid=%b, expected busy=0 ready=0000 valid=0",
               busy, req_ready, fifo_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    sb.push_back(ent(0, 0)); sb.push_back(ent(1, 1)); sb.push_back(ent(1, 2)); sb.push_back(ent(1, 3));
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      @(negedge clk);
      got = req_ready;
      if (fifo_valid === 1'b1 && fifo_ready === 1'b1) begin
        total++;
        exp_v = sb.pop_front();
        if (fifo_data !== exp_v) begin bad++; $display("FAIL mbr_beat: got %h, expected %h", fifo_data, exp_v); end
      end
      cyc++;
      finish_cycle(got);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL mbr_drain: got %0d beats left, expected 0", sb.size());
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    fifo_ready = 1'b0;
    clear_reqs();
    drive();
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_burst_limit();
    test_mid_burst_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
